// File: rtl/color_symbol_decoder.sv
// Decodes a stream of RGB sensor samples into 2-bit color symbols.
// A symbol is accepted after STABLE_COUNT matching samples, and only once a qualified gap has been seen.
module color_symbol_decoder #(
   parameter int STABLE_COUNT = 4,
   parameter int THRESH       = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sampleValid,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   output logic       colorReady,
   output logic [1:0] color,
   output logic [7:0] glitchCount
);

   localparam logic [1:0] SEEK_GAP    = 2'd0;
   localparam logic [1:0] WAIT_SYMBOL = 2'd1;
   localparam logic [1:0] QUALIFY     = 2'd2;
   localparam logic [1:0] HOLD        = 2'd3;

   localparam logic [3:0] STABLE_LIM = 4'(STABLE_COUNT);
   localparam logic [7:0] THRESH_LVL = 8'(THRESH);

   logic [1:0] state;
   logic [3:0] gap_cnt;
   logic [3:0] run_cnt;
   logic [1:0] candidate;

   logic       red_hi;
   logic       green_hi;
   logic       blue_hi;
   logic       is_gap;
   logic       is_color;
   logic [1:0] sample_code;
   logic       gap_done;
   logic       run_done;
   logic [7:0] glitch_next;

   always_comb begin
      red_hi      = (red >= THRESH_LVL);
      green_hi    = (green >= THRESH_LVL);
      blue_hi     = (blue >= THRESH_LVL);
      is_gap      = 1'b0;
      is_color    = 1'b0;
      sample_code = 2'b00;
      case ({red_hi, green_hi, blue_hi})
         3'b100: begin is_color = 1'b1; sample_code = 2'b00; end
         3'b010: begin is_color = 1'b1; sample_code = 2'b01; end
         3'b001: begin is_color = 1'b1; sample_code = 2'b10; end
         3'b110: begin is_color = 1'b1; sample_code = 2'b11; end
         3'b000: is_gap = 1'b1;
         default: begin is_gap = 1'b0; is_color = 1'b0; end
      endcase
   end

   // Terminal-count detection and the saturating glitch increment
   always_comb begin
      gap_done    = ((gap_cnt + 4'd1) == STABLE_LIM);
      run_done    = ((run_cnt + 4'd1) == STABLE_LIM);
      glitch_next = (glitchCount == 8'hFF) ? glitchCount : glitchCount + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEEK_GAP;
         gap_cnt     <= 4'd0;
         run_cnt     <= 4'd0;
         candidate   <= 2'b00;
         colorReady  <= 1'b0;
         color       <= 2'b00;
         glitchCount <= 8'd0;
      end else begin
         colorReady <= 1'b0;
         if (sampleValid) begin
            case (state)
               SEEK_GAP, HOLD: begin
                  if (is_gap) begin
                     if (gap_done) begin
                        gap_cnt <= 4'd0;
                        state   <= WAIT_SYMBOL;
                     end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                     end
                  end else begin
                     gap_cnt <= 4'd0;
                  end
               end
               WAIT_SYMBOL: begin
                  if (is_color) begin
                     candidate <= sample_code;
                     run_cnt   <= 4'd1;
                     state     <= QUALIFY;
                  end
               end
               QUALIFY: begin
                  if (is_color && sample_code == candidate) begin
                     if (run_done) begin
                        run_cnt    <= 4'd0;
                        gap_cnt    <= 4'd0;
                        colorReady <= 1'b1;
                        color      <= candidate;
                        state      <= HOLD;
                     end else begin
                        run_cnt <= run_cnt + 4'd1;
                     end
                  end else if (is_color) begin
                     candidate   <= sample_code;
                     run_cnt     <= 4'd1;
                     glitchCount <= glitch_next;
                  end else begin
                     // Gap or invalid pattern aborts the run
                     run_cnt     <= 4'd0;
                     glitchCount <= glitch_next;
                     state       <= WAIT_SYMBOL;
                  end
               end
               default: state <= SEEK_GAP;
            endcase
         end
      end
   end

endmodule

// File: doc/color_symbol_decoder.md
COLOR_SYMBOL_DECODER -- requirements
Module: color_symbol_decoder

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 4, consecutive matching samples needed to accept a symbol or a gap; legal range 2..15.
REQ-002 SHALL have parameter THRESH, default 128, 8-bit level at or above which a channel reads "high".
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sampleValid  input  1  red/green/blue hold a new sensor sample this cycle.
REQ-006 SHALL have port red  input  8  red channel intensity.
REQ-007 SHALL have port green  input  8  green channel intensity.
REQ-008 SHALL have port blue  input  8  blue channel intensity.
REQ-009 SHALL have port colorReady  output  1  one-cycle strobe: a new symbol is on color.
REQ-010 SHALL have port color  output  2  decoded symbol: R=00, G=01, B=10, Y=11.
REQ-011 SHALL have port glitchCount  output  8  count of aborted symbol qualifications, saturating.

Function
REQ-012 SHALL classify each valid sample (H = channel >= THRESH): H/L/L red; L/H/L green; L/L/H blue; H/H/L yellow; L/L/L gap; any other pattern invalid.
REQ-013 SHALL ignore all inputs in cycles with sampleValid=0; counters and state hold.
REQ-014 SHALL implement states SEEK_GAP, WAIT_SYMBOL, QUALIFY, HOLD.
REQ-015 SEEK_GAP: gap counter increments per gap sample, clears on any non-gap sample; reaching STABLE_COUNT moves to WAIT_SYMBOL (partial symbol at power-up never emitted).
REQ-016 WAIT_SYMBOL: color sample latches candidate, sets run counter to 1, moves to QUALIFY; gap/invalid samples stay.
REQ-017 QUALIFY, sample equal to candidate: run counter increments; when it reaches STABLE_COUNT, move to HOLD and emit.
REQ-018 QUALIFY, different color: candidate replaced, run counter = 1, glitchCount +1, stay.
REQ-019 QUALIFY, invalid: run counter cleared, glitchCount +1, return to WAIT_SYMBOL.
REQ-020 QUALIFY, gap: glitchCount +1, return to WAIT_SYMBOL.
REQ-021 Emit: colorReady SHALL be high exactly one cycle, the cycle after the qualifying sample's clock edge; color updates on that same edge.
REQ-022 color SHALL hold its last emitted value until the next emit.
REQ-023 HOLD: no further emits; gap counter as in SEEK_GAP; STABLE_COUNT consecutive gap samples move to WAIT_SYMBOL.
REQ-024 A repeated color SHALL only emit again after a qualified gap (e.g. R,gap,R gives two symbols).
REQ-025 Emits SHALL be separated by at least 2*STABLE_COUNT valid samples, so colorReady is never high on consecutive cycles.
REQ-026 glitchCount SHALL saturate at 255, never wrap.
REQ-027 Counters SHALL be 4 bits; run/gap counters never exceed STABLE_COUNT.

Reset
REQ-028 When reset=1 at a clock edge: state SEEK_GAP; colorReady 0; color 00; glitchCount 0; gap, run, candidate cleared.
REQ-029 Reset SHALL override sampleValid on the same edge; mid-QUALIFY reset discards the candidate with no emit and no glitchCount change.
REQ-030 After reset release, no emit SHALL occur before a qualified gap.

Verification (STABLE_COUNT=4, THRESH=128)
REQ-031 Reset; 4 gap samples (0,0,0); 4 samples (200,10,10) -> one colorReady pulse, color=00, one cycle after 4th red sample; glitchCount=0.
REQ-032 Reset; 4 yellow (200,200,10) with no gap first -> no colorReady; then 4 gap, 4 blue (10,10,200) -> one pulse, color=10.
REQ-033 After qualified gap: green x2, blue x1, blue x3 -> glitchCount=1, one pulse color=10.
REQ-034 Qualified gap, then red x4, gap x3, red x4 -> exactly one pulse; adding a 4th gap sample between runs -> two pulses, both color=00.
REQ-035 Qualified gap, green x3, reset asserted, green x4 -> no pulse, glitchCount=0, state SEEK_GAP.
REQ-036 300 alternating red/green single samples after qualified gap -> glitchCount=255, no pulse.
